// File: rtl/ultrasonic_trig_gen_pkg.sv
// Shared definitions for the ultrasonic ranging blocks.
// Holds the trigger FSM state encoding and the measurement error codes.
// The echo pulse-width counter uses the same error codes.
package ultrasonic_trig_gen_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_WAIT_FALL = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NO_ECHO = 2'b01;
  localparam logic [1:0] ERR_LONG    = 2'b10;

endpackage

// File: rtl/echo_edge_sync.sv
// Echo line synchroniser: two flops, then rise/fall strobes.
// Latency: an echo edge shows up as a one-cycle strobe after the first flop captures it.
// Always accepts input, so there is no backpressure. Also used by the echo pulse-width counter.
module echo_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;

  // Two-flop synchroniser for the asynchronous echo line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= echo_i;
      s2_q <= s1_q;
    end
  end

  // A level that is already high never produces a rise, so a stuck line is not an echo
  assign rise_o = s1_q & ~s2_q;
  assign fall_o = ~s1_q & s2_q;

endmodule

// File: rtl/ultrasonic_trig_gen.sv
// Ultrasonic trigger generator: fires the sensor trigger, times the echo, flags timeouts.
// Latency: trig rises one cycle after leaving IDLE; meas_done pulses one cycle after the deciding edge or timeout.
// No backpressure; with TRIG_ONESHOT_EN defined, start is only honoured in IDLE and is otherwise dropped.
module ultrasonic_trig_gen
  import ultrasonic_trig_gen_pkg::*;
#(
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned PERIOD_US  = 60000,
  parameter int unsigned RISE_TO_US = 5000,
  parameter int unsigned ECHO_TO_US = 38000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       clk_1m,
  input  logic       rst,
  input  logic       echo,
`ifdef TRIG_ONESHOT_EN
  input  logic       start,
`endif
  output logic       trig,
  output logic       busy,
  output logic       meas_done,
  output logic [1:0] err
);

  // Last counter value of each timed phase
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TO_US - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_TO_US - 1);
  // HOLDOFF exits one count early because IDLE takes one cycle before the next TRIG,
  // so trigger rises land exactly PERIOD_US cycles apart.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PERIOD_US - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic             rise;
  logic             fall;
  logic             go;

  echo_edge_sync u_echo_edge_sync (
    .clk_i  (clk_1m),
    .rst_i  (rst),
    .echo_i (echo),
    .rise_o (rise),
    .fall_o (fall)
  );

`ifdef TRIG_ONESHOT_EN
  assign go = start;
`else
  assign go = 1'b1;
`endif

  // State, counters and registered outputs
  always_ff @(posedge clk_1m) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      per_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      per_q   <= per_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; an echo edge on the timeout cycle takes priority over the timeout
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    per_d   = per_q + 1'b1;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (go) begin
          state_d = ST_TRIG;
          per_d   = '0;
        end
      end
      ST_TRIG: begin
        if (phase_q == TRIG_LAST) begin
          state_d = ST_WAIT_RISE;
          phase_d = '0;
        end
      end
      ST_WAIT_RISE: begin
        if (rise) begin
          state_d = ST_WAIT_FALL;
          phase_d = '0;
        end else if (phase_q == RISE_LAST) begin
          state_d = ST_HOLDOFF;
          done_d  = 1'b1;
          err_d   = ERR_NO_ECHO;
        end
      end
      ST_WAIT_FALL: begin
        if (fall) begin
          state_d = ST_HOLDOFF;
          done_d  = 1'b1;
          err_d   = ERR_OK;
        end else if (phase_q == ECHO_LAST) begin
          state_d = ST_HOLDOFF;
          done_d  = 1'b1;
          err_d   = ERR_LONG;
        end
      end
      ST_HOLDOFF: begin
        if (per_q >= HOLD_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    trig_d = (state_d == ST_TRIG);
    busy_d = (state_d != ST_IDLE);
  end

  assign trig      = trig_q;
  assign busy      = busy_q;
  assign meas_done = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ultrasonic_trig_gen.sv
// Directed bench for ultrasonic_trig_gen with shortened timing parameters.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled at that point.
// cyc holds the index of the most recent rising edge.
module tb_ultrasonic_trig_gen;

  localparam int TRIG = 10;
  localparam int PER  = 6000;
  localparam int RTO  = 500;
  localparam int ETO  = 3800;

  logic       clk_1m = 1'b0;
  logic       rst    = 1'b1;
  logic       echo   = 1'b0;
`ifdef TRIG_ONESHOT_EN
  logic       start  = 1'b0;
`endif
  logic       trig;
  logic       busy;
  logic       meas_done;
  logic [1:0] err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int md_cnt   = 0;
  int t0;
  int at;
  int m0;

  ultrasonic_trig_gen #(
    .TRIG_US    (TRIG),
    .PERIOD_US  (PER),
    .RISE_TO_US (RTO),
    .ECHO_TO_US (ETO),
    .CNT_W      (20)
  ) dut (
    .clk_1m    (clk_1m),
    .rst       (rst),
    .echo      (echo),
`ifdef TRIG_ONESHOT_EN
    .start     (start),
`endif
    .trig      (trig),
    .busy      (busy),
    .meas_done (meas_done),
    .err       (err)
  );

  always #5 clk_1m = ~clk_1m;

  // Count meas_done pulses, sampled on the falling edge
  always @(negedge clk_1m) if (meas_done === 1'b1) md_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1m);
    cyc += n;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Returns the cycle at which trig is first seen high, or -1 if the bound expires
  task automatic wait_trig_rise(input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim && t < 0; i++) begin
      tick(1);
      if (trig === 1'b1) t = cyc;
    end
  endtask

  // Returns the cycle at which meas_done is first seen high, or -1 if the bound expires
  task automatic wait_md(input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim && t < 0; i++) begin
      tick(1);
      if (meas_done === 1'b1) t = cyc;
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", meas_done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
`ifdef TRIG_ONESHOT_EN
    // Without start the block stays idle
    tick(20);
    chk("os_idle_trig", trig, 0);
    chk("os_idle_busy", busy, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("os_trig_on_start", trig, 1);
    t0 = cyc;
    tick(20);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_md(RTO + 100, at);
    chk("os_md_time", at, t0 + TRIG + RTO);
    chk("os_err_no_echo", err, 1);
    // The start while busy was dropped, so no further trigger appears
    wait_trig_rise(2 * PER, at);
    chk("os_no_retrigger", at, -1);
    chk("os_busy_end", busy, 0);
`else
    // Trigger high for cycles 1..10 after reset release
    tick(1);
    chk("trig_c1", trig, 1);
    chk("busy_c1", busy, 1);
    t0 = cyc;
    tick(9);
    chk("trig_c10", trig, 1);
    tick(1);
    chk("trig_c11", trig, 0);

    // Normal echo: 100 cycles after trig falls, 2000 cycles wide
    tick(100);
    echo = 1'b1;
    tick(2000);
    chk("no_done_during_echo", md_cnt, 0);
    echo = 1'b0;
    tick(1);
    chk("done_not_yet", meas_done, 0);
    tick(1);
    chk("done_ok", meas_done, 1);
    chk("err_ok", err, 0);
    tick(1);
    chk("done_one_cycle", meas_done, 0);
    chk("done_count_1", md_cnt, 1);

    // Period after a normal measurement
    wait_trig_rise(PER, at);
    chk("period_1", at, t0 + PER);
    t0 = at;

    // No echo: timeout RTO cycles after WAIT_RISE entry
    wait_md(TRIG + RTO + 100, at);
    chk("no_echo_time", at, t0 + TRIG + RTO);
    chk("err_no_echo", err, 1);
    wait_trig_rise(PER, at);
    chk("period_2", at, t0 + PER);
    t0 = at;

    // Echo stuck high longer than the echo timeout
    tick(TRIG);
    chk("trig_low_t4", trig, 0);
    tick(50);
    echo = 1'b1;
    // Rise captured at +61, WAIT_FALL entered at +62
    wait_md(ETO + 100, at);
    chk("long_echo_time", at, t0 + 62 + ETO);
    chk("err_long", err, 2);
    tick(1);
    m0 = md_cnt;
    tick(t0 + 60 + 4000 - cyc);
    echo = 1'b0;
    wait_trig_rise(PER, at);
    chk("period_3", at, t0 + PER);
    chk("no_second_done", md_cnt, m0);
    chk("err_held", err, 2);
    t0 = at;

    // Reset pulsed during WAIT_FALL
    tick(30);
    echo = 1'b1;
    tick(100);
    chk("busy_before_rst", busy, 1);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_trig", trig, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", meas_done, 0);
    chk("rst_mid_err", err, 0);
    echo = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("restart_trig", trig, 1);
    chk("restart_no_done", md_cnt, m0);
    tick(TRIG);
    chk("restart_trig_low", trig, 0);
    tick(5);
    echo = 1'b1;
    tick(50);
    echo = 1'b0;
    t0 = cyc;
    wait_md(10, at);
    chk("restart_done_time", at, t0 + 2);
    chk("restart_err_ok", err, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
